// File: rtl/display_scheduler.sv
// Sequences the three two-digit values shown on the six-digit HEX display:
// rotating PRICE/TRADE/SPREAD pages, a trade-hold after each match, and a halt blink.
module display_scheduler #(
   parameter int unsigned ROTATE_CYCLES = 150_000_000,
   parameter int unsigned HOLD_CYCLES   = 100_000_000,
   parameter int unsigned BLINK_CYCLES  = 12_500_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] buy_price,
   input  logic [7:0] sell_price,
   input  logic [7:0] spread_now,
   input  logic [7:0] trade_count,
   input  logic       halt_signal,
   input  logic       match_signal,
   input  logic       page_next,
   input  logic       auto_en,
   input  logic       clr_stats,
   output logic [7:0] disp_a,
   output logic [7:0] disp_b,
   output logic [7:0] disp_c,
   output logic       blank,
   output logic [1:0] page,
   output logic       hold_active
);

   localparam logic [27:0] ROT_LAST   = 28'(ROTATE_CYCLES - 1);
   localparam logic [27:0] HOLD_LAST  = 28'(HOLD_CYCLES - 1);
   localparam logic [27:0] BLINK_LAST = 28'(BLINK_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_SHOW = 2'd0,
      ST_HOLD = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t      r_state;
   logic [1:0]  r_page;
   logic [1:0]  r_saved_page;
   logic        r_from_hold;
   logic        r_hold_active;
   logic        r_blank;
   logic        r_match_d;
   logic [27:0] r_rot_cnt;
   logic [27:0] r_hold_cnt;
   logic [27:0] r_blink_cnt;
   logic [7:0]  r_last_buy;
   logic [7:0]  r_last_sell;
   logic [7:0]  r_spread_max;
   logic [7:0]  r_spread_min;
   logic [7:0]  r_buy_p0;
   logic [7:0]  r_sell_p0;
   logic [7:0]  r_spread_p0;
   logic [7:0]  r_trades_p0;
   logic [7:0]  r_disp_a_p1;
   logic [7:0]  r_disp_b_p1;
   logic [7:0]  r_disp_c_p1;
   logic [7:0]  w_mux_a;
   logic [7:0]  w_mux_b;
   logic [7:0]  w_mux_c;
   logic        w_match_rise;
   logic        w_disp_en;

   function automatic logic [7:0] clamp99(input logic [7:0] v);
      return (v > 8'd99) ? 8'd99 : v;
   endfunction

   function automatic logic [1:0] next_page(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   assign w_match_rise = match_signal & ~r_match_d;
   assign w_disp_en    = ~halt_signal && (r_state != ST_HALT);

   // Control FSM: halt > match > page key > auto-rotate
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_SHOW;
         r_page        <= 2'd0;
         r_saved_page  <= 2'd0;
         r_from_hold   <= 1'b0;
         r_hold_active <= 1'b0;
         r_blank       <= 1'b0;
         r_match_d     <= 1'b0;
         r_rot_cnt     <= '0;
         r_hold_cnt    <= '0;
         r_blink_cnt   <= '0;
         r_last_buy    <= 8'd0;
         r_last_sell   <= 8'd0;
      end else begin
         r_match_d <= match_signal;
         if (halt_signal) begin
            if (r_state != ST_HALT) begin
               r_state       <= ST_HALT;
               r_from_hold   <= (r_state == ST_HOLD);
               r_hold_active <= 1'b0;
               r_blank       <= 1'b0;
               r_blink_cnt   <= '0;
            end else if (r_blink_cnt == BLINK_LAST) begin
               r_blank     <= ~r_blank;
               r_blink_cnt <= '0;
            end else begin
               r_blink_cnt <= r_blink_cnt + 28'd1;
            end
         end else begin
            case (r_state)
               ST_SHOW: begin
                  if (w_match_rise) begin
                     r_last_buy    <= buy_price;
                     r_last_sell   <= sell_price;
                     r_saved_page  <= r_page;
                     r_page        <= 2'd1;
                     r_hold_cnt    <= HOLD_LAST;
                     r_hold_active <= 1'b1;
                     r_state       <= ST_HOLD;
                  end else if (page_next) begin
                     r_page    <= next_page(r_page);
                     r_rot_cnt <= '0;
                  end else if (auto_en) begin
                     if (r_rot_cnt == ROT_LAST) begin
                        r_page    <= next_page(r_page);
                        r_rot_cnt <= '0;
                     end else begin
                        r_rot_cnt <= r_rot_cnt + 28'd1;
                     end
                  end else begin
                     r_rot_cnt <= '0;
                  end
               end
               ST_HOLD: begin
                  if (w_match_rise) begin
                     r_last_buy  <= buy_price;
                     r_last_sell <= sell_price;
                     r_hold_cnt  <= HOLD_LAST;
                  end else if (r_hold_cnt == 28'd0) begin
                     r_page        <= r_saved_page;
                     r_rot_cnt     <= '0;
                     r_hold_active <= 1'b0;
                     r_state       <= ST_SHOW;
                  end else begin
                     r_hold_cnt <= r_hold_cnt - 28'd1;
                  end
               end
               ST_HALT: begin
                  if (r_from_hold) r_page <= r_saved_page;
                  r_rot_cnt <= '0;
                  r_blank   <= 1'b0;
                  r_state   <= ST_SHOW;
               end
               default: r_state <= ST_SHOW;
            endcase
         end
      end
   end

   // Spread extremes follow the live spread outside HALT; a clear always wins
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_spread_max <= 8'd0;
         r_spread_min <= 8'd255;
      end else if (clr_stats) begin
         r_spread_max <= 8'd0;
         r_spread_min <= 8'd255;
      end else if (r_state != ST_HALT) begin
         if (spread_now > r_spread_max) r_spread_max <= spread_now;
         if (spread_now < r_spread_min) r_spread_min <= spread_now;
      end
   end

   // Stage p0: register live datapath inputs
   always_ff @(posedge clk) begin
      r_buy_p0    <= buy_price;
      r_sell_p0   <= sell_price;
      r_spread_p0 <= spread_now;
      r_trades_p0 <= trade_count;
   end

   always_comb begin
      w_mux_a = r_buy_p0;
      w_mux_b = r_sell_p0;
      w_mux_c = r_spread_p0;
      case (r_page)
         2'd1: begin
            w_mux_a = r_last_buy;
            w_mux_b = r_last_sell;
            w_mux_c = r_trades_p0;
         end
         2'd2: begin
            w_mux_a = r_spread_max;
            w_mux_b = r_spread_min;
            w_mux_c = r_spread_p0;
         end
         default: ;
      endcase
   end

   // Stage p1: clamped page mux to the display outputs, frozen during halt
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_disp_a_p1 <= 8'd0;
         r_disp_b_p1 <= 8'd0;
         r_disp_c_p1 <= 8'd0;
      end else if (w_disp_en) begin
         r_disp_a_p1 <= clamp99(w_mux_a);
         r_disp_b_p1 <= clamp99(w_mux_b);
         r_disp_c_p1 <= clamp99(w_mux_c);
      end
   end

   assign disp_a      = r_disp_a_p1;
   assign disp_b      = r_disp_b_p1;
   assign disp_c      = r_disp_c_p1;
   assign blank       = r_blank;
   assign page        = r_page;
   assign hold_active = r_hold_active;

endmodule
